mem_arbiter: RTL and testbench

- Arbitrates one single-ported, variable-latency unified memory between the pipeline's fetch stage (IF port) and memory stage (D port).
- Generates per-port stall signals; the stalls feed the hazard logic's stall/flush network.
- Sequences one memory transaction at a time with a req/ack handshake and a watchdog timeout.

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arb_watchdog.sv | 41 ++++
 rtl/mem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// Round-robin arbitration is enabled by defining MEM_ARB_RR_EN.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_I = 2'b01,
    BUSY_D = 2'b10,
    RESP   = 2'b11
  } arb_state_e;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_D  = 1'b1;

  localparam int DEF_TIMEOUT = 255;
  localparam int DEF_CNTW    = 8;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Busy-cycle watchdog: cleared when a transaction starts, counts while busy,
// flags expiry on the cycle whose count would reach TIMEOUT.
module mem_arb_watchdog
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNTW    = DEF_CNTW
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [CNTW-1:0] LAST = CNTW'(TIMEOUT - 1);

  logic [CNTW-1:0] cnt_q, cnt_d;

  // NOTE: next-state logic assigns its default first so no path leaves cnt_d unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments and are all cleared by the async reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Single-ported memory arbiter between fetch (IF) and data (D) ports with
// req/ack sequencing and watchdog timeout. Define MEM_ARB_RR_EN for round-robin.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNTW    = DEF_CNTW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  input  logic             if_kill,
  output logic             if_valid,
  output logic [WIDTH-1:0] if_rdata,
  output logic             if_stall,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_valid,
  output logic [WIDTH-1:0] d_rdata,
  output logic             d_stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             err
);

  arb_state_e       state_q, state_d;
  logic             if_valid_q, if_valid_d, d_valid_q, d_valid_d;
  logic [WIDTH-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic             mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [WIDTH-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic             err_q, err_d, killed_q, killed_d;
  logic             wd_clr, wd_en, wd_expire;
  logic             grant_d_port;

  mem_arb_watchdog #(.TIMEOUT(TIMEOUT), .CNTW(CNTW)) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expire_o (wd_expire)
  );

`ifdef MEM_ARB_RR_EN
  logic last_gnt_q, last_gnt_d;

  // On contention the port that lost last time wins; a sole requester always wins.
  assign grant_d_port = d_req && (!if_req || (last_gnt_q == GNT_IF));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_gnt_q <= GNT_IF;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (state_q == IDLE && (d_req || if_req)) begin
      last_gnt_d = grant_d_port ? GNT_D : GNT_IF;
    end
  end
`else
  // D belongs to the older instruction, so it always wins contention.
  assign grant_d_port = d_req;
`endif

  always_comb begin
    state_d     = state_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;
    killed_d    = killed_q;
    wd_clr      = 1'b0;
    wd_en       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (d_req || if_req) begin
          wd_clr    = 1'b1;
          killed_d  = 1'b0;
          mem_req_d = 1'b1;
          if (grant_d_port) begin
            state_d     = BUSY_D;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end else begin
            state_d     = BUSY_I;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
          end
        end
      end
      BUSY_I, BUSY_D: begin
        wd_en = 1'b1;
        if (state_q == BUSY_I && if_kill) begin
          killed_d = 1'b1;
        end
        // An ack on the expiry cycle still counts as a completed transaction.
        if (mem_ack || wd_expire) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          if (!mem_ack) begin
            err_d = 1'b1;
          end
          if (state_q == BUSY_D) begin
            d_valid_d = 1'b1;
            d_rdata_d = (mem_ack && !mem_we_q) ? mem_rdata : '0;
          end else begin
            if_valid_d = !(killed_q || if_kill);
            if_rdata_d = mem_ack ? mem_rdata : '0;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
      killed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
      killed_q    <= killed_d;
    end
  end

  assign if_valid  = if_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_valid   = d_valid_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;
  assign if_stall  = if_req && !if_valid_q;
  assign d_stall   = d_req && !d_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized transaction-level bench for mem_arbiter; a requester/memory model
// predicts grant, memory fields, valid pulses, rdata, err and stalls.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int W   = 32;
  localparam int TMO = 8;
  localparam int CW  = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         if_req, if_kill, if_valid, if_stall;
  logic [W-1:0] if_addr, if_rdata;
  logic         d_req, d_we, d_valid, d_stall;
  logic [W-1:0] d_addr, d_wdata, d_rdata;
  logic         mem_req, mem_we, mem_ack, err;
  logic [W-1:0] mem_addr, mem_wdata, mem_rdata;

  mem_arbiter #(.WIDTH(W), .TIMEOUT(TMO), .CNTW(CW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_valid(if_valid), .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  logic last_gnt = GNT_IF;
  logic err_exp  = 1'b0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic raise_if();
    if_req  = 1'b1;
    if_addr = $urandom & 32'hFFFF_FFFC;
  endtask

  task automatic raise_d();
    d_req   = 1'b1;
    d_we    = 1'($urandom_range(0, 1));
    d_addr  = $urandom & 32'hFFFF_FFFC;
    d_wdata = $urandom;
  endtask

  // Called at the falling edge of an IDLE cycle with requests already driven.
  // lat: BUSY cycle carrying mem_ack (0 = never); kill_at/drop_at: BUSY cycle of a fetch kill / data drop.
  task automatic run_txn(input int lat, input int kill_at, input int drop_at, input logic [W-1:0] rd);
    logic         gd, killed, timed_out, exp_ifv, e_we;
    logic [W-1:0] e_addr, e_wdata, e_rdata;
    #1;
    check("idle_mem_req", 32'(mem_req), 32'd0);
    check("idle_if_valid", 32'(if_valid), 32'd0);
    check("idle_d_valid", 32'(d_valid), 32'd0);
    check("idle_if_stall", 32'(if_stall), 32'(if_req));
    check("idle_d_stall", 32'(d_stall), 32'(d_req));
    if (d_req && if_req) begin
`ifdef MEM_ARB_RR_EN
      gd = (last_gnt == GNT_IF) ? GNT_D : GNT_IF;
`else
      gd = GNT_D;
`endif
    end else begin
      gd = d_req ? GNT_D : GNT_IF;
    end
    last_gnt  = gd;
    e_addr    = (gd == GNT_D) ? d_addr : if_addr;
    e_we      = (gd == GNT_D) ? d_we : 1'b0;
    e_wdata   = d_wdata;
    killed    = 1'b0;
    timed_out = 1'b1;
    for (int busy = 1; busy <= TMO; busy++) begin
      @(negedge clk);
      check("busy_mem_req", 32'(mem_req), 32'd1);
      check("busy_mem_addr", mem_addr, e_addr);
      check("busy_mem_we", 32'(mem_we), 32'(e_we));
      if (e_we) check("busy_mem_wdata", mem_wdata, e_wdata);
      if_kill = 1'b0;
      if (busy == 1 && $urandom_range(0, 3) == 0) begin
        if (gd == GNT_D && !if_req) raise_if();
        if (gd == GNT_IF && !d_req) raise_d();
      end
      if (busy == kill_at && gd == GNT_IF) begin
        if_kill = 1'b1;
        if_req  = 1'b0;
        if_addr = $urandom;
        killed  = 1'b1;
      end
      if (busy == drop_at && gd == GNT_D) begin
        d_req   = 1'b0;
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = $urandom;
        d_wdata = $urandom;
      end
      mem_ack   = (busy == lat);
      mem_rdata = (busy == lat) ? rd : $urandom;
      if (busy == lat) begin
        timed_out = 1'b0;
        break;
      end
    end
    @(negedge clk);
    if_kill = 1'b0;
    mem_ack = 1'b0;
    err_exp = err_exp | timed_out;
    e_rdata = (timed_out || e_we) ? '0 : rd;
    exp_ifv = (gd == GNT_IF) && !killed;
    check("resp_mem_req", 32'(mem_req), 32'd0);
    check("resp_err", 32'(err), 32'(err_exp));
    check("resp_d_valid", 32'(d_valid), 32'(gd == GNT_D));
    check("resp_if_valid", 32'(if_valid), 32'(exp_ifv));
    if (gd == GNT_D) check("resp_d_rdata", d_rdata, e_rdata);
    if (exp_ifv) check("resp_if_rdata", if_rdata, e_rdata);
    check("resp_if_stall", 32'(if_stall), 32'(if_req && !exp_ifv));
    check("resp_d_stall", 32'(d_stall), 32'(d_req && gd != GNT_D));
    // Requester retires on its valid; stray ack/kill in RESP must be ignored.
    if (gd == GNT_D) d_req = 1'b0;
    else if_req = 1'b0;
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    if_kill   = 1'($urandom_range(0, 1));
    @(negedge clk);
    mem_ack = 1'b0;
    if_kill = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    {if_req, if_kill, d_req, d_we, mem_ack} = '0;
    {if_addr, d_addr, d_wdata, mem_rdata} = '0;
    repeat (2) @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_d_valid", 32'(d_valid), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Single fetch, 3-cycle memory.
    if_req = 1'b1; if_addr = 32'h40;
    run_txn(3, 0, 0, 32'h2010_0005);
    // Contention with 1-cycle memory: both requests rise together.
    if_req = 1'b1; if_addr = 32'h44;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_wdata = 32'h0;
    run_txn(1, 0, 0, 32'hCAFE_0001);
    run_txn(1, 0, 0, 32'hCAFE_0002);
    // Store: d_rdata must read 0.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'hDEAD_BEEF;
    run_txn(2, 0, 0, 32'h1234_5678);
    // Killed fetch, then a normal fetch.
    if_req = 1'b1; if_addr = 32'h44;
    run_txn(3, 2, 0, 32'h5555_AAAA);
    if_req = 1'b1; if_addr = 32'h60;
    run_txn(2, 0, 0, 32'h0BAD_F00D);
    // Kill asserted in IDLE has no effect; ack exactly on the expiry cycle is a completion.
    if_req = 1'b1; if_addr = 32'h70; if_kill = 1'b1;
    run_txn(TMO, 0, 0, 32'h7777_0000);
    // Dropped data request still completes.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h90; d_wdata = 32'h0;
    run_txn(3, 0, 1, 32'h9999_0001);

    for (int it = 0; it < 150; it++) begin
      int lat;
      if (!if_req && $urandom_range(0, 1) == 1) raise_if();
      if (!d_req && $urandom_range(0, 1) == 1) raise_d();
      if (!if_req && !d_req) raise_if();
      if (if_req && $urandom_range(0, 7) == 0) if_kill = 1'b1;
      if ($urandom_range(0, 5) == 0) mem_ack = 1'b1;
      case ($urandom_range(0, 15))
        0:       lat = 0;
        1:       lat = TMO;
        default: lat = $urandom_range(1, 5);
      endcase
      run_txn(lat,
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
              $urandom);
    end

    // Timeout on a load: mem_req drops after TMO busy cycles, err sticks, d_rdata = 0.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'hA0; d_wdata = 32'h0;
    run_txn(0, 0, 0, 32'hFFFF_FFFF);
    if_req = 1'b1; if_addr = 32'hB0;
    run_txn(2, 0, 0, 32'h0000_B0B0);

    // Asynchronous reset in the middle of a transaction.
    if_req = 1'b1; if_addr = 32'h200;
    @(negedge clk);
    check("pre_rst_mem_req", 32'(mem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_mem_req", 32'(mem_req), 32'd0);
    check("async_rst_mem_addr", mem_addr, 32'd0);
    check("async_rst_err", 32'(err), 32'd0);
    check("async_rst_if_rdata", if_rdata, 32'd0);
    check("async_rst_valid", 32'({if_valid, d_valid}), 32'd0);
    err_exp  = 1'b0;
    last_gnt = GNT_IF;
    @(negedge clk);
    rst = 1'b1;
    run_txn(2, 0, 0, 32'h2222_0200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
